// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM state encoding, baud counter width, default baud constant.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } uart_state_e;

   // 115200 baud from a 100 MHz system clock
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

   function automatic int unsigned cnt_width(input int unsigned clks);
      return (clks < 2) ? 1 : $clog2(clks);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic bit_end
);

   localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (restart || !en) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bit_end = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with internal baud timing and valid/ready input.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned MSB_FIRST    = 1,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 tx_busy,
   output logic                 tx_done
);

   if (CLKS_PER_BIT < 2) begin : gen_bad_clks
      $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data
      $error("uart_tx_param: DATA_BITS must be within 5..9");
   end
   if (MSB_FIRST > 1 || PARITY_ODD > 1) begin : gen_bad_flag
      $error("uart_tx_param: MSB_FIRST and PARITY_ODD must be 0 or 1");
   end

   localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   uart_state_e          state_q;
   logic [IDX_W-1:0]     bit_idx_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic [DATA_BITS-1:0] shreg_next;
   logic                 next_bit;
   logic                 bit_end;
   logic                 handshake;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q;
`endif

   assign tx_ready  = (state_q == StIdle);
   assign tx_busy   = !tx_ready;
   assign handshake = tx_valid && tx_ready;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .en     (tx_busy),
      .restart(handshake),
      .bit_end(bit_end)
   );

   // Head of the shift register is the next bit on the line
   always_comb begin
      next_bit   = 1'b1;
      shreg_next = shreg_q;
      if (MSB_FIRST != 0) begin
         next_bit   = shreg_q[DATA_BITS-1];
         shreg_next = {shreg_q[DATA_BITS-2:0], 1'b0};
      end else begin
         next_bit   = shreg_q[0];
         shreg_next = {1'b0, shreg_q[DATA_BITS-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         tx_out    <= 1'b1;
         tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               tx_out <= 1'b1;
               if (tx_valid) begin
                  shreg_q   <= tx_data;
                  bit_idx_q <= '0;
                  tx_out    <= 1'b0;
                  state_q   <= StStart;
`ifdef UART_TX_PARITY_EN
                  parity_q  <= (^tx_data) ^ PARITY_ODD[0];
`endif
               end
            end
            StStart: begin
               if (bit_end) begin
                  tx_out  <= next_bit;
                  shreg_q <= shreg_next;
                  state_q <= StData;
               end
            end
            StData: begin
               if (bit_end) begin
                  if (bit_idx_q == LAST_DATA) begin
                     bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                     tx_out    <= parity_q;
                     state_q   <= StParity;
`else
                     tx_out    <= 1'b1;
                     state_q   <= StStop;
`endif
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                     tx_out    <= next_bit;
                     shreg_q   <= shreg_next;
                  end
               end
            end
            StParity: begin
`ifdef UART_TX_PARITY_EN
               if (bit_end) begin
                  tx_out  <= 1'b1;
                  state_q <= StStop;
               end
`else
               tx_out  <= 1'b1;
               state_q <= StIdle;
`endif
            end
            StStop: begin
               if (bit_end) begin
                  if (bit_idx_q == LAST_STOP) begin
                     bit_idx_q <= '0;
                     tx_done   <= 1'b1;
                     state_q   <= StIdle;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end
            end
            default: begin
               tx_out  <= 1'b1;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: two configurations checked every cycle against a frame-level model.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   localparam int CPB_A = 4, DB_A = 8, STOP_A = 1;
   localparam bit MSB_A = 1'b1, ODD_A = 1'b0;
   localparam int CPB_B = 2, DB_B = 5, STOP_B = 2;
   localparam bit MSB_B = 1'b0, ODD_B = 1'b1;
   localparam int N_A = 1 + DB_A + int'(PAR) + STOP_A;
   localparam int N_B = 1 + DB_B + int'(PAR) + STOP_B;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [DB_A-1:0] data_a = '0;
   logic [DB_B-1:0] data_b = '0;
   logic valid_a = 1'b0, valid_b = 1'b0;
   logic ready_a, out_a, busy_a, done_a;
   logic ready_b, out_b, busy_b, done_b;

   int total = 0, bad = 0, cyc = 0;
   bit checking = 1'b0, stop_b = 1'b0, fin_b = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_param #(
      .CLKS_PER_BIT(CPB_A), .DATA_BITS(DB_A), .MSB_FIRST(MSB_A), .STOP_BITS(STOP_A),
      .PARITY_ODD(ODD_A)
   ) dut_a (
      .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
      .tx_out(out_a), .tx_busy(busy_a), .tx_done(done_a)
   );

   uart_tx_param #(
      .CLKS_PER_BIT(CPB_B), .DATA_BITS(DB_B), .MSB_FIRST(MSB_B), .STOP_BITS(STOP_B),
      .PARITY_ODD(ODD_B)
   ) dut_b (
      .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
      .tx_out(out_b), .tx_busy(busy_b), .tx_done(done_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting for tx_ready (t=%0t)", name, $time);
   endtask

   // Line bits in send order: start, data, optional parity, then 1s for stop/idle
   function automatic logic [15:0] frame_bits(input logic [8:0] d, input int db, input bit msb,
                                              input bit par, input bit odd);
      logic [15:0] f;
      int k;
      bit p;
      f = '1;
      f[0] = 1'b0;
      k = 1;
      p = odd;
      for (int i = 0; i < db; i++) begin
         f[k] = msb ? d[db-1-i] : d[i];
         p ^= d[i];
         k++;
      end
      if (par) f[k] = p;
      return f;
   endfunction

   // Frame model: position in clocks since the accepting edge
   logic act_a = 1'b0, mdone_a = 1'b0, act_b = 1'b0, mdone_b = 1'b0;
   int pos_a = 0, pos_b = 0;
   logic [15:0] fr_a = '1, fr_b = '1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         act_a <= 1'b0; pos_a <= 0; mdone_a <= 1'b0;
      end else begin
         mdone_a <= 1'b0;
         if (act_a) begin
            if (pos_a == N_A * CPB_A - 1) begin
               act_a <= 1'b0; mdone_a <= 1'b1;
            end else pos_a <= pos_a + 1;
         end else if (valid_a) begin
            act_a <= 1'b1; pos_a <= 0;
            fr_a <= frame_bits(9'(data_a), DB_A, MSB_A, PAR, ODD_A);
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         act_b <= 1'b0; pos_b <= 0; mdone_b <= 1'b0;
      end else begin
         mdone_b <= 1'b0;
         if (act_b) begin
            if (pos_b == N_B * CPB_B - 1) begin
               act_b <= 1'b0; mdone_b <= 1'b1;
            end else pos_b <= pos_b + 1;
         end else if (valid_b) begin
            act_b <= 1'b1; pos_b <= 0;
            fr_b <= frame_bits(9'(data_b), DB_B, MSB_B, PAR, ODD_B);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (checking) begin
            check("a_line",  32'(out_a),   32'(act_a ? fr_a[pos_a / CPB_A] : 1'b1));
            check("a_ready", 32'(ready_a), 32'(!act_a));
            check("a_busy",  32'(busy_a),  32'(act_a));
            check("a_done",  32'(done_a),  32'(mdone_a));
            check("b_line",  32'(out_b),   32'(act_b ? fr_b[pos_b / CPB_B] : 1'b1));
            check("b_ready", 32'(ready_b), 32'(!act_b));
            check("b_busy",  32'(busy_b),  32'(act_b));
            check("b_done",  32'(done_b),  32'(mdone_b));
         end
      end
   end

   // Returns just after the accepting edge; tx_valid is left high
   task automatic send_a(input logic [DB_A-1:0] d, output int hs);
      int budget;
      budget = 0;
      @(negedge clk);
      data_a = d;
      valid_a = 1'b1;
      while (!ready_a && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!ready_a) timeout("a_send");
      @(posedge clk);
      #1;
      hs = cyc;
      data_a = DB_A'($urandom);
   endtask

   task automatic send_b(input logic [DB_B-1:0] d);
      int budget;
      budget = 0;
      @(negedge clk);
      data_b = d;
      valid_b = 1'b1;
      while (!ready_b && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!ready_b) timeout("b_send");
      @(posedge clk);
      #1;
      data_b = DB_B'($urandom);
   endtask

   initial begin : stim_b
      logic [0:N_B-1] lit_b;
      int done_at;
`ifdef UART_TX_PARITY_EN
      lit_b = 9'b011111011;
`else
      lit_b = 8'b01111111;
`endif
      wait (checking);
      send_b(5'h1F);
      valid_b = 1'b0;
      done_at = -1;
      for (int j = 0; j < N_B * CPB_B + 2; j++) begin
         @(negedge clk);
         if (j % CPB_B == 1 && j / CPB_B < N_B) check("b_lit_bit", 32'(out_b), 32'(lit_b[j / CPB_B]));
         if (done_b && done_at < 0) done_at = j;
      end
      check("b_done_time", 32'(done_at), 32'(N_B * CPB_B));
      while (!stop_b) begin
         send_b(DB_B'($urandom));
         if ($urandom_range(0, 2) == 0) valid_b = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      valid_b = 1'b0;
      fin_b = 1'b1;
   end

   initial begin : stim_a
      logic [0:N_A-1] lit_a;
      int hs1, hs2, done_at, low_cnt, budget;
`ifdef UART_TX_PARITY_EN
      lit_a = 11'b01010010101;
`else
      lit_a = 10'b0101001011;
`endif
      // Reset values
      @(negedge clk);
      check("rst_out",   32'(out_a),   32'd1);
      check("rst_ready", 32'(ready_a), 32'd1);
      check("rst_busy",  32'(busy_a),  32'd0);
      check("rst_done",  32'(done_a),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      checking = 1'b1;

      // 0xA5 against hand-computed line bits and frame length
      send_a(8'hA5, hs1);
      valid_a = 1'b0;
      done_at = -1;
      low_cnt = 0;
      for (int j = 0; j < N_A * CPB_A + 2; j++) begin
         @(negedge clk);
         if (j % CPB_A == 2 && j / CPB_A < N_A) check("a_lit_bit", 32'(out_a), 32'(lit_a[j / CPB_A]));
         if (j < N_A * CPB_A && !ready_a) low_cnt++;
         if (done_a && done_at < 0) done_at = j;
      end
      check("a_done_time", 32'(done_at), 32'(N_A * CPB_A));
      check("a_ready_low", 32'(low_cnt), 32'(N_A * CPB_A));

      // tx_valid held: next start bit one clock after tx_done
      send_a(8'h3C, hs1);
      send_a(8'hC3, hs2);
      valid_a = 1'b0;
      check("a_b2b_gap", 32'(hs2 - hs1), 32'(N_A * CPB_A + 1));

      send_a(8'h07, hs1);
      valid_a = 1'b0;

      for (int n = 0; n < 10; n++) begin
         send_a(DB_A'($urandom), hs1);
         if ($urandom_range(0, 1) == 0) valid_a = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      valid_a = 1'b0;

      // Reset during data bit 3 abandons the frame
      send_a(DB_A'($urandom), hs1);
      valid_a = 1'b0;
      repeat (17) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_out",   32'(out_a),   32'd1);
      check("mid_rst_ready", 32'(ready_a), 32'd1);
      check("mid_rst_done",  32'(done_a),  32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(ready_a), 32'd1);

      send_a(8'h55, hs1);
      valid_a = 1'b0;
      repeat (N_A * CPB_A + 4) @(negedge clk);

      stop_b = 1'b1;
      budget = 0;
      while (!fin_b && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      if (!fin_b) timeout("b_finish");
      repeat (N_B * CPB_B + 4) @(negedge clk);
      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter that replaces the fixed 8-bit, MSB-first, externally-ticked TX controller.
- Generates its own baud timing from the system clock.
- Configurable: data width, bit order, stop-bit count, optional parity.
- Accepts bytes on a valid/ready handshake and drives the serial line `tx_out`.
- Sits between the video-control command path and the board UART pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (≥2); 868 = 115200 baud at 100 MHz
DATA_BITS, 8, data bits per frame (5..9)
MSB_FIRST, 1, 1 = data[DATA_BITS-1] sent first; 0 = LSB first (standard UART)
STOP_BITS, 1, number of stop bits (1 or 2)
PARITY_ODD, 0, parity sense when parity is compiled in; 0 = even, 1 = odd

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tx_data  in  DATA_BITS  payload; sampled only on handshake
tx_valid  in  1  payload valid
tx_ready  out  1  block can accept a payload
tx_out  out  1  serial line, idle high
tx_busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse at end of last stop bit

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk.
- Reset values: tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- Output timing:
  - tx_ready is high exactly while state==IDLE.
  - tx_busy = !tx_ready.
  - tx_out is registered.
- Handshake:
  - Transfer occurs on a clk edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register on that edge.
  - tx_data and tx_valid are ignored whenever tx_ready=0.
  - tx_valid may be held high; a new frame starts only when IDLE is re-entered.
- State machine:
  - IDLE -> START on handshake.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> (PARITY | STOP) after DATA_BITS bit periods.
  - PARITY -> STOP after one bit period.
  - STOP -> IDLE after STOP_BITS bit periods.
- Line values per state:
  - START: tx_out=0 from the cycle after the handshake.
  - DATA: current shift-register bit.
  - PARITY: parity bit.
  - STOP: 1.
  - IDLE: 1.
- Bit timing:
  - Every bit is exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1, restarts on the handshake, and wraps at each bit boundary.
  - Counter width is $clog2(CLKS_PER_BIT).
- Frame length, handshake edge to return to IDLE: CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS) cycles, where P = 1 if parity is compiled in, else 0.
- tx_done:
  - Asserted for one cycle, coincident with the transition STOP->IDLE.
  - tx_ready rises on the same edge.
- Back-to-back frames:
  - A handshake in the first IDLE cycle starts the next start bit one cycle later.
  - Minimum inter-frame idle on the line is therefore 1 clk.
- Bit order:
  - MSB_FIRST=1: shift left, output the MSB.
  - MSB_FIRST=0: shift right, output the LSB.
- Reset mid-frame:
  - tx_out returns to 1 immediately (asynchronous).
  - The frame is abandoned and no tx_done is generated.
- Invalid parameters: STOP_BITS outside {1,2}, or CLKS_PER_BIT<2, are rejected at elaboration by a generate-time error.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after the last data bit.
  - Parity bit = ^data_latched XOR PARITY_ODD, computed when the data is latched.
- Undefined:
  - No PARITY state and no parity logic.
  - PARITY_ODD is ignored.
  - DATA goes directly to STOP.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP; 3-bit encoding);
  - localparam helpers for counter width;
  - the default baud constant.
- Sub-module uart_baud_gen:
  - CLKS_PER_BIT counter with synchronous restart input;
  - emits a one-cycle bit_end tick;
  - reusable by the future RX block.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, MSB_FIRST=1, parity off; send 0xA5 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each held 4 clk; tx_done one pulse 40 clk after handshake; tx_ready low for exactly those 40 clk.
2. MSB_FIRST=0, same data 0xA5 -> data bits on the line 1,0,1,0,0,1,0,1.
3. UART_TX_PARITY_EN defined, PARITY_ODD=0, STOP_BITS=2; send 0x07 -> parity bit 1, two stop bits; frame = 12 bit periods = 48 clk.
4. tx_valid held high with 0x3C then 0xC3 -> second start bit begins exactly 1 clk after the first frame's tx_done; a tx_data change mid-frame has no effect on the line.
5. Assert rst during data bit 3 -> tx_out=1 in the same cycle; no tx_done; after release, tx_ready=1 and the next frame 0x55 is transmitted correctly.
6. DATA_BITS=5, CLKS_PER_BIT=2; send 0x1F -> 5 data bits of 1; frame = 7 bit periods = 14 clk.
